// File: rtl/core_pkg.sv
// Shared EX-stage encodings: ALU ops, flag-update modes, forwarding selects, flag bit layout.
// Pure declarations; no logic, latency or backpressure of its own.
package core_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_NOR  = 4'd3;
  localparam logic [3:0] OP_SLL  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_SRA  = 4'd6;
  localparam logic [3:0] OP_PASS = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;

  localparam logic [1:0] FM_NONE = 2'b00;
  localparam logic [1:0] FM_Z    = 2'b01;
  localparam logic [1:0] FM_NVZ  = 2'b10;
  localparam logic [1:0] FM_ADDZ = 2'b11;

  localparam logic [1:0] FWD_REG     = 2'b00;
  localparam logic [1:0] FWD_MEM     = 2'b01;
  localparam logic [1:0] FWD_WB      = 2'b10;
  localparam logic [1:0] FWD_REG_ALT = 2'b11;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef struct packed {
    logic z;
    logic v;
    logic n;
  } flags_t;

endpackage

// File: rtl/ex_stage_mc_if.sv
// ex_stage_mc_if: ID/EX-side inputs and EX/MEM-side outputs of the execute stage.
// Combinational bundle; stall_in throttles EX from downstream, ex_busy throttles the front end.
interface ex_stage_mc_if #(
  parameter int DW     = 16,
  parameter int IMM_W  = 8,
  parameter int JOFF_W = 12,
  parameter int SHW    = 4
);
  logic              stall_in;
  logic              valid_in;
  logic [3:0]        alu_op;
  logic [1:0]        src0_sel;
  logic [1:0]        src1_sel;
  logic              alu_src;
  logic [IMM_W-1:0]  imm;
  logic [SHW-1:0]    shamt;
  logic [JOFF_W-1:0] jump_offset;
  logic [DW-1:0]     p0_data;
  logic [DW-1:0]     p1_data;
  logic [DW-1:0]     mem_fwd;
  logic [DW-1:0]     wb_fwd;
  logic [DW-1:0]     pc_plus_one;
  logic              jump_from_reg;
  logic              is_jal;
  logic              reg_write_in;
  logic [1:0]        flag_mode;
  logic [DW-1:0]     result;
  logic [DW-1:0]     data_mem_data;
  logic [DW-1:0]     jump_addr;
  logic [2:0]        flags;
  logic              reg_write_out;
  logic              result_valid;
  logic              ex_busy;

  modport master (
    output stall_in, valid_in, alu_op, src0_sel, src1_sel, alu_src, imm, shamt,
           jump_offset, p0_data, p1_data, mem_fwd, wb_fwd, pc_plus_one,
           jump_from_reg, is_jal, reg_write_in, flag_mode,
    input  result, data_mem_data, jump_addr, flags, reg_write_out, result_valid, ex_busy
  );

  modport slave (
    input  stall_in, valid_in, alu_op, src0_sel, src1_sel, alu_src, imm, shamt,
           jump_offset, p0_data, p1_data, mem_fwd, wb_fwd, pc_plus_one,
           jump_from_reg, is_jal, reg_write_in, flag_mode,
    output result, data_mem_data, jump_addr, flags, reg_write_out, result_valid, ex_busy
  );
endinterface

// File: rtl/ex_mul_iter.sv
// ex_mul_iter: iterative shift-add multiplier, IDLE->BUSY (DW steps)->DONE; product ready DW+1 cycles after start.
// stall_in only holds DONE; stepping in BUSY never pauses, busy covers the start cycle and BUSY.
module ex_mul_iter #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stall_in,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          rw_in,
  input  logic [1:0]    mode_in,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] product,
  output logic          rw,
  output logic [1:0]    mode
);
  localparam int CW = $clog2(DW + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] mcand_q, mcand_d;
  logic [DW-1:0] mplier_q, mplier_d;
  logic [DW-1:0] acc_q, acc_d;
  logic          rw_q, rw_d;
  logic [1:0]    mode_q, mode_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    rw_d     = rw_q;
    mode_d   = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_BUSY;
          cnt_d    = '0;
          mcand_d  = a;
          mplier_d = b;
          acc_d    = '0;
          rw_d     = rw_in;
          mode_d   = mode_in;
        end
      end
      ST_BUSY: begin
        // Product only needs the low DW bits, so the multiplicand simply shifts out the top.
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(DW - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!stall_in) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      rw_q     <= 1'b0;
      mode_q   <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      rw_q     <= rw_d;
      mode_q   <= mode_d;
    end
  end

  assign busy    = ((state_q == ST_IDLE) && start) || (state_q == ST_BUSY);
  assign done    = (state_q == ST_DONE);
  assign product = acc_q;
  assign rw      = rw_q;
  assign mode    = mode_q;
endmodule

// File: rtl/ex_stage_mc.sv
// ex_stage_mc: forwarding, ALU, Z/V/N flags, jump target; single-cycle ops are combinational, MUL takes DW+2 cycles.
// Optional multiplier under `define EX_MUL_EN; ex_busy stalls the front end, stall_in freezes flags and holds DONE.
module ex_stage_mc
  import core_pkg::*;
#(
  parameter int DW     = 16,
  parameter int IMM_W  = 8,
  parameter int JOFF_W = 12,
  parameter int SHW    = 4
) (
  input logic          clk,
  input logic          rst,
  ex_stage_mc_if.slave ex
);
  logic [DW-1:0]     fwd_src0, fwd_src1, alu_b, alu_res, res_val;
  logic [IMM_W-1:0]  imm_raw;
  logic [JOFF_W-1:0] joff_raw;
  logic [SHW-1:0]    shamt;
  logic [DW-1:0]     joff_ext;
  logic              shift_oob, alu_v, res_ovf, res_vld, commit, is_mul, cur_rw;
  logic [1:0]        cur_mode;
  flags_t            flags_q, flags_d;
  logic              mul_busy, mul_done, mul_rw;
  logic [DW-1:0]     mul_prod;
  logic [1:0]        mul_mode;

  function automatic logic [DW-1:0] fwd_pick(input logic [1:0] sel, input logic [DW-1:0] reg_v,
                                             input logic [DW-1:0] mem_v, input logic [DW-1:0] wb_v);
    case (sel)
      FWD_MEM: return mem_v;
      FWD_WB:  return wb_v;
      default: return reg_v;
    endcase
  endfunction

  assign imm_raw   = ex.imm;
  assign joff_raw  = ex.jump_offset;
  assign shamt     = ex.shamt;
  assign joff_ext  = DW'($signed(joff_raw));
  assign fwd_src0  = fwd_pick(ex.src0_sel, ex.p0_data, ex.mem_fwd, ex.wb_fwd);
  assign fwd_src1  = fwd_pick(ex.src1_sel, ex.p1_data, ex.mem_fwd, ex.wb_fwd);
  assign alu_b     = ex.alu_src ? DW'(imm_raw) : fwd_src1;
  assign shift_oob = (32'(shamt) >= DW);
  assign is_mul    = (ex.alu_op == OP_MUL);

  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    case (ex.alu_op)
      OP_ADD: begin
        alu_res = fwd_src0 + alu_b;
        alu_v   = (fwd_src0[DW-1] == alu_b[DW-1]) && (alu_res[DW-1] != fwd_src0[DW-1]);
      end
      OP_SUB: begin
        alu_res = fwd_src0 - alu_b;
        alu_v   = (fwd_src0[DW-1] != alu_b[DW-1]) && (alu_res[DW-1] != fwd_src0[DW-1]);
      end
      OP_AND:  alu_res = fwd_src0 & alu_b;
      OP_NOR:  alu_res = ~(fwd_src0 | alu_b);
      OP_SLL:  alu_res = shift_oob ? '0 : (fwd_src0 << shamt);
      OP_SRL:  alu_res = shift_oob ? '0 : (fwd_src0 >> shamt);
      OP_SRA:  alu_res = shift_oob ? '0 : $unsigned($signed(fwd_src0) >>> shamt);
      OP_PASS: alu_res = alu_b;
      default: alu_res = '0;
    endcase
  end

`ifdef EX_MUL_EN
  ex_mul_iter #(.DW(DW)) u_mul (
    .clk      (clk),
    .rst      (rst),
    .start    (ex.valid_in && is_mul && !ex.stall_in),
    .stall_in (ex.stall_in),
    .a        (fwd_src0),
    .b        (alu_b),
    .rw_in    (ex.reg_write_in),
    .mode_in  (ex.flag_mode),
    .busy     (mul_busy),
    .done     (mul_done),
    .product  (mul_prod),
    .rw       (mul_rw),
    .mode     (mul_mode)
  );
`else
  assign mul_busy = 1'b0;
  assign mul_done = 1'b0;
  assign mul_prod = '0;
  assign mul_rw   = 1'b0;
  assign mul_mode = FM_NONE;
`endif

  // DONE wins over whatever sits on the inputs: the MUL is still held in ID/EX during DONE.
  always_comb begin
    if (mul_done) begin
      res_val  = mul_prod;
      res_ovf  = 1'b0;
      cur_mode = mul_mode;
      cur_rw   = mul_rw;
      res_vld  = 1'b1;
      commit   = !ex.stall_in;
    end else begin
      res_val  = ex.is_jal ? ex.pc_plus_one : alu_res;
      res_ovf  = alu_v;
      cur_mode = ex.flag_mode;
      cur_rw   = ex.reg_write_in && !is_mul;
      res_vld  = ex.valid_in && !is_mul;
      commit   = ex.valid_in && !is_mul && !ex.stall_in && !mul_busy;
    end
    flags_d = flags_q;
    if (commit) begin
      case (cur_mode)
        FM_Z: flags_d.z = (res_val == '0);
        FM_NVZ, FM_ADDZ: begin
          flags_d.z = (res_val == '0);
          flags_d.v = res_ovf;
          flags_d.n = res_val[DW-1];
        end
        default: flags_d = flags_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign ex.result        = res_val;
  assign ex.result_valid  = res_vld;
  assign ex.reg_write_out = (cur_mode == FM_ADDZ) ? (cur_rw && flags_q.z) : cur_rw;
  assign ex.data_mem_data = fwd_src1;
  assign ex.jump_addr     = ex.jump_from_reg ? fwd_src0 : (ex.pc_plus_one + joff_ext);
  assign ex.flags         = flags_q;
  assign ex.ex_busy       = mul_busy;
endmodule
